// File: rtl/vid_pkg.sv
// Shared geometry constants and the sync/enable bundle for the text-mode scanout.
package vid_pkg;

  localparam int VID_COLS     = 32;
  localparam int VID_ROWS     = 16;
  localparam int VID_CELL_W   = 8;
  localparam int VID_CELL_H   = 12;
  localparam int VID_ACT_W    = 256;
  localparam int VID_ACT_H    = 192;
  localparam int VID_PIPE_LAT = 3;

  // Control signals that travel alongside the pixel through the delay pipe.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic frame_start;
  } vid_ctl_t;

endpackage

// File: rtl/vid_timing.sv
// Raster counters, character row/line tracking, active flags and raw sync
// generation; also produces the look-ahead fetch strobe for the video RAM.
module vid_timing
  import vid_pkg::*;
#(
  parameter int H_TOTAL      = 320,
  parameter int H_SYNC_START = 280,
  parameter int H_SYNC_LEN   = 24,
  parameter int V_TOTAL      = 262,
  parameter int V_SYNC_START = 224,
  parameter int V_SYNC_LEN   = 3
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] phase,
  output logic       h_act,
  output logic       v_act,
  output logic [3:0] line,
  output logic       fetch,
  output logic [4:0] fetch_col,
  output logic [3:0] fetch_row,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       origin
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [3:0]    row;
  logic          h_wrap;
  logic          v_wrap;
  int            h_ahead;

  assign h_wrap = (int'(h) == H_TOTAL - 1);
  assign v_wrap = (int'(v) == V_TOTAL - 1);

  // NOTE: all state uses non-blocking assignments under the async reset so
  // every register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h    <= '0;
      v    <= '0;
      row  <= '0;
      line <= '0;
    end else if (h_wrap) begin
      h <= '0;
      if (v_wrap) begin
        v    <= '0;
        row  <= '0;
        line <= '0;
      end else begin
        v <= v + 1'b1;
        if (line == 4'(VID_CELL_H - 1)) begin
          line <= '0;
          row  <= row + 4'd1;
        end else begin
          line <= line + 4'd1;
        end
      end
    end else begin
      h <= h + 1'b1;
    end
  end

  assign phase     = h[2:0];
  assign h_act     = int'(h) < VID_ACT_W;
  assign v_act     = int'(v) < VID_ACT_H;
  assign origin    = (h == '0) && (v == '0);
  assign hsync_raw = (int'(h) >= H_SYNC_START) && (int'(h) < H_SYNC_START + H_SYNC_LEN);
  assign vsync_raw = (int'(v) >= V_SYNC_START) && (int'(v) < V_SYNC_START + V_SYNC_LEN);

  // The address is issued two clocks ahead so that the registered RAM and
  // font stages land the glyph in the shifter exactly 3 clocks after h.
  // Column 0 is therefore fetched at the end of the previous line.
  always_comb begin
    h_ahead   = int'(h) + 2;
    fetch     = 1'b0;
    fetch_col = 5'(h_ahead / VID_CELL_W);
    fetch_row = row;
    if (h_ahead == H_TOTAL) begin
      fetch_col = '0;
      fetch     = v_wrap || (int'(v) < VID_ACT_H - 1);
      fetch_row = v_wrap ? 4'd0 : (line == 4'(VID_CELL_H - 1)) ? row + 4'd1 : row;
    end else begin
      fetch = v_act && (h_ahead < VID_ACT_W) && (h_ahead % VID_CELL_W == 0);
    end
  end

endmodule

// File: rtl/vid_scanout.sv
// Text-mode scanout: character fetch, font lookup, pixel shifter and sync
// alignment. Optional cell inversion via VID_SCANOUT_INVERSE_EN.
module vid_scanout
  import vid_pkg::*;
#(
  parameter int          H_TOTAL      = 320,
  parameter int          H_SYNC_START = 280,
  parameter int          H_SYNC_LEN   = 24,
  parameter int          V_TOTAL      = 262,
  parameter int          V_SYNC_START = 224,
  parameter int          V_SYNC_LEN   = 3,
  parameter logic [10:0] BASE_ADDR    = 11'h000,
  parameter bit          SYNC_POL     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] vid_addr,
  input  logic [7:0]  vid_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pixel,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  if (H_SYNC_START + H_SYNC_LEN > H_TOTAL || H_TOTAL <= 259) begin : g_bad_h
    $error("vid_scanout: horizontal timing parameters out of range");
  end
  if (VID_COLS * VID_CELL_W != VID_ACT_W || VID_ROWS * VID_CELL_H != VID_ACT_H) begin : g_bad_geom
    $error("vid_scanout: inconsistent character geometry");
  end

  localparam vid_ctl_t CTL_IDLE = '{de: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL, frame_start: 1'b0};

  logic [2:0] phase;
  logic       h_act, v_act;
  logic [3:0] line;
  logic       fetch;
  logic [4:0] fetch_col;
  logic [3:0] fetch_row;
  logic       hsync_raw, vsync_raw, origin;
  logic [7:0] shreg;
  logic [7:0] glyph;
  vid_ctl_t   ctl_now;
  vid_ctl_t   pipe [VID_PIPE_LAT];

  vid_timing #(
    .H_TOTAL(H_TOTAL), .H_SYNC_START(H_SYNC_START), .H_SYNC_LEN(H_SYNC_LEN),
    .V_TOTAL(V_TOTAL), .V_SYNC_START(V_SYNC_START), .V_SYNC_LEN(V_SYNC_LEN)
  ) u_timing (
    .clk, .reset, .phase, .h_act, .v_act, .line, .fetch, .fetch_col,
    .fetch_row, .hsync_raw, .vsync_raw, .origin
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_addr  <= BASE_ADDR;
      font_addr <= '0;
      shreg     <= '0;
    end else begin
      if (fetch) vid_addr <= BASE_ADDR + {2'b00, fetch_row, fetch_col};
      if (phase == 3'd0 && h_act && v_act) font_addr <= {vid_data[6:0], line};
      // Reload takes priority over the shift, so characters abut seamlessly.
      if (phase == 3'd2) shreg <= (h_act && v_act) ? glyph : 8'h00;
      else               shreg <= {shreg[6:0], 1'b0};
    end
  end

`ifdef VID_SCANOUT_INVERSE_EN
  logic inv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                inv <= 1'b0;
    else if (phase == 3'd0 && h_act && v_act) inv <= vid_data[7];
  end

  assign glyph = font_data ^ {8{inv}};
`else
  logic unused_attr;

  assign unused_attr = vid_data[7];
  assign glyph       = font_data;
`endif

  always_comb begin
    ctl_now             = CTL_IDLE;
    ctl_now.de          = h_act && v_act;
    ctl_now.hsync       = hsync_raw ? SYNC_POL : ~SYNC_POL;
    ctl_now.vsync       = vsync_raw ? SYNC_POL : ~SYNC_POL;
    ctl_now.frame_start = origin;
  end

  // NOTE: the delay pipe is a handful of flops, not a RAM, so it is reset
  // explicitly to keep outputs clean from the first clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VID_PIPE_LAT; i++) pipe[i] <= CTL_IDLE;
    end else begin
      pipe[0] <= ctl_now;
      for (int i = 1; i < VID_PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign pixel       = shreg[7];
  assign de          = pipe[VID_PIPE_LAT-1].de;
  assign hsync       = pipe[VID_PIPE_LAT-1].hsync;
  assign vsync       = pipe[VID_PIPE_LAT-1].vsync;
  assign frame_start = pipe[VID_PIPE_LAT-1].frame_start;

endmodule
